// File: rtl/instruction_writer.sv
// Program loader: packs instruction fields into 32-bit words, writes them to
// instruction memory at consecutive addresses and verifies each by readback.
module instruction_writer #(
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned MAX_WORDS = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              finish,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        opcode,
  input  logic [4:0]        reg_addr_0,
  input  logic [4:0]        reg_addr_1,
  input  logic [4:0]        reg_addr_2,
  input  logic [14:0]       addr,
  output logic [ADDR_W-1:0] imem_address,
  output logic              imem_write_en,
  output logic [31:0]       imem_write_data,
  input  logic [31:0]       imem_read_data,
  output logic              busy,
  output logic              full,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   word_count
);

  localparam int unsigned CNT_W  = ADDR_W + 1;
  localparam int unsigned WORD_W = 32;
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WORDS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCEPT,
    S_WRITE,
    S_CHECK,
    S_DONE,
    S_ERROR
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [WORD_W-1:0]   word_q, word_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                error_q, error_d;
  logic                in_ready_q, in_ready_d;
  logic                wr_en_q, wr_en_d;
  logic                busy_q, busy_d;
  logic                full_q, full_d;
  logic                done_q, done_d;
  logic [WORD_W-1:0]   enc_c;
  logic                full_c;

  // Decoder-compatible packing; the unused tail field is zeroed.
  always_comb begin
    enc_c = {opcode, reg_addr_0, reg_addr_1, 19'd0};
    if (opcode[2]) begin
      enc_c[18:0] = {4'd0, addr};
    end else begin
      enc_c[18:0] = {reg_addr_2, 14'd0};
    end
  end

  assign full_c = (cnt_q == MAX_CNT);

  // Next-state logic; outputs are registered from the next-state decode.
  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    word_d   = word_q;
    cnt_d    = cnt_q;
    error_d  = error_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          wr_ptr_d = base_addr;
          cnt_d    = '0;
          error_d  = 1'b0;
          state_d  = S_ACCEPT;
        end
      end
      S_ACCEPT: begin
        // A bundle wins over finish in the same cycle; finish is then dropped.
        if (in_valid && !full_c) begin
          word_d  = enc_c;
          state_d = S_WRITE;
        end else if (finish) begin
          state_d = S_DONE;
        end
      end
      S_WRITE: begin
        state_d = S_CHECK;
      end
      S_CHECK: begin
        if (imem_read_data == word_q) begin
          wr_ptr_d = wr_ptr_q + ADDR_W'(1);
          cnt_d    = cnt_q + CNT_W'(1);
          state_d  = S_ACCEPT;
        end else begin
          error_d = 1'b1;
          state_d = S_ERROR;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      S_ERROR: begin
        state_d = S_ERROR;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    in_ready_d = (state_d == S_ACCEPT) && (cnt_d != MAX_CNT);
    wr_en_d    = (state_d == S_WRITE);
    busy_d     = (state_d != S_IDLE);
    full_d     = (cnt_d == MAX_CNT);
    done_d     = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      word_q     <= '0;
      cnt_q      <= '0;
      error_q    <= 1'b0;
      in_ready_q <= 1'b0;
      wr_en_q    <= 1'b0;
      busy_q     <= 1'b0;
      full_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      word_q     <= word_d;
      cnt_q      <= cnt_d;
      error_q    <= error_d;
      in_ready_q <= in_ready_d;
      wr_en_q    <= wr_en_d;
      busy_q     <= busy_d;
      full_q     <= full_d;
      done_q     <= done_d;
    end
  end

  assign in_ready        = in_ready_q;
  assign imem_address    = wr_ptr_q;
  assign imem_write_en   = wr_en_q;
  assign imem_write_data = word_q;
  assign busy            = busy_q;
  assign full            = full_q;
  assign done            = done_q;
  assign error           = error_q;
  assign word_count      = cnt_q;

endmodule

// File: tb/tb_instruction_writer.sv
// Self-checking bench for instruction_writer: encoding table, multi-cycle
// corner sequences and randomized sessions against a simple session model.
module tb_instruction_writer;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned MAXW   = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic              finish;
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        opcode;
  logic [4:0]        reg_addr_0, reg_addr_1, reg_addr_2;
  logic [14:0]       addr;
  logic [ADDR_W-1:0] imem_address;
  logic              imem_write_en;
  logic [31:0]       imem_write_data;
  logic [31:0]       imem_read_data;
  logic              busy, full, done, error;
  logic [ADDR_W:0]   word_count;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  logic corrupt   = 1'b0;
  logic [31:0] mem [0:65535];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Instruction memory with combinational read; corrupt forces a bad readback.
  always @(posedge clk) if (imem_write_en) mem[imem_address] <= imem_write_data;
  assign imem_read_data = corrupt ? 32'hDEADBEEF : mem[imem_address];

  instruction_writer #(.ADDR_W(ADDR_W), .MAX_WORDS(MAXW)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .finish(finish), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .reg_addr_0(reg_addr_0), .reg_addr_1(reg_addr_1),
    .reg_addr_2(reg_addr_2), .addr(addr), .imem_address(imem_address),
    .imem_write_en(imem_write_en), .imem_write_data(imem_write_data),
    .imem_read_data(imem_read_data), .busy(busy), .full(full), .done(done),
    .error(error), .word_count(word_count)
  );

  typedef struct {
    logic [2:0]  op;
    logic [4:0]  r0, r1, r2;
    logic [14:0] a;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl [7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Field-level model of the word format, built arithmetically.
  function automatic logic [31:0] ref_enc(input int op, input int r0, input int r1,
                                           input int r2, input int a);
    longint w;
    w = longint'(op) * 64'd536870912 + longint'(r0) * 64'd16777216 + longint'(r1) * 64'd524288;
    if (op >= 4) w = w + longint'(a);
    else         w = w + longint'(r2) * 64'd16384;
    return 32'(w);
  endfunction

  task automatic set_fields(input logic [2:0] op, input logic [4:0] r0, input logic [4:0] r1,
                            input logic [4:0] r2, input logic [14:0] a);
    opcode = op; reg_addr_0 = r0; reg_addr_1 = r1; reg_addr_2 = r2; addr = a;
  endtask

  // Present a bundle until accepted; returns at the negedge of the WRITE cycle.
  task automatic send_bundle(input logic [2:0] op, input logic [4:0] r0, input logic [4:0] r1,
                             input logic [4:0] r2, input logic [14:0] a);
    bit ok;
    ok = 0;
    set_fields(op, r0, r1, r2, a);
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (in_ready) begin ok = 1; break; end
      tick();
    end
    if (!ok) chk("in_ready_wait", 64'(ok), 64'd1);
    else tick();
    in_valid = 1'b0;
  endtask

  // One full word transaction; returns at the negedge back in ACCEPT.
  task automatic bundle_and_check(input string tag, input logic [2:0] op, input logic [4:0] r0,
                                  input logic [4:0] r1, input logic [4:0] r2, input logic [14:0] a,
                                  input logic [31:0] exp_word, input logic [15:0] exp_addr,
                                  input int exp_cnt, output int wcyc);
    send_bundle(op, r0, r1, r2, a);
    wcyc = cyc;
    chk({tag, "_wen"}, 64'(imem_write_en), 64'd1);
    chk({tag, "_waddr"}, 64'(imem_address), 64'(exp_addr));
    chk({tag, "_wdata"}, 64'(imem_write_data), 64'(exp_word));
    tick();
    chk({tag, "_wen_check"}, 64'(imem_write_en), 64'd0);
    tick();
    chk({tag, "_count"}, 64'(word_count), 64'(exp_cnt));
  endtask

  task automatic start_session(input logic [15:0] base);
    base_addr = base;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_busy", 64'(busy), 64'd1);
    chk("start_ready", 64'(in_ready), 64'd1);
    chk("start_count", 64'(word_count), 64'd0);
  endtask

  task automatic finish_session(input int exp_cnt);
    finish = 1'b1;
    tick();
    finish = 1'b0;
    chk("done_pulse", 64'(done), 64'd1);
    tick();
    chk("done_drop", 64'(done), 64'd0);
    chk("idle_busy", 64'(busy), 64'd0);
    chk("held_count", 64'(word_count), 64'(exp_cnt));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int c1, c2, c3, n, gap, base;
    logic [2:0] op; logic [4:0] r0, r1, r2; logic [14:0] a;

    tbl[0] = '{3'b010, 5'd1,  5'd2,  5'd3,  15'h7FFF, 32'h4110C000};
    tbl[1] = '{3'b101, 5'd4,  5'd0,  5'd31, 15'h1234, 32'hA4001234};
    tbl[2] = '{3'b000, 5'd0,  5'd0,  5'd0,  15'h7FFF, 32'h00000000};
    tbl[3] = '{3'b111, 5'd31, 5'd31, 5'd31, 15'h7FFF, 32'hFFF87FFF};
    tbl[4] = '{3'b011, 5'd31, 5'd31, 5'd31, 15'h0000, 32'h7FFFC000};
    tbl[5] = '{3'b100, 5'd0,  5'd0,  5'd31, 15'h0000, 32'h80000000};
    tbl[6] = '{3'b001, 5'd16, 5'd1,  5'd1,  15'h5555, 32'h30084000};

    reset = 1'b1; start = 1'b0; finish = 1'b0; in_valid = 1'b0; base_addr = '0;
    set_fields(3'd0, 5'd0, 5'd0, 5'd0, 15'd0);
    tick(); tick();
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_wen", 64'(imem_write_en), 64'd0);
    chk("rst_addr", 64'(imem_address), 64'd0);
    chk("rst_wdata", 64'(imem_write_data), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_flags", 64'({full, done, error}), 64'd0);
    chk("rst_count", 64'(word_count), 64'd0);
    reset = 1'b0;
    tick();

    // Encoding table, one single-word session per entry.
    foreach (tbl[i]) begin
      start_session(16'h0010 + 16'(i));
      bundle_and_check($sformatf("tbl%0d", i), tbl[i].op, tbl[i].r0, tbl[i].r1, tbl[i].r2,
                       tbl[i].a, tbl[i].exp, 16'h0010 + 16'(i), 1, c1);
      finish_session(1);
    end

    // Back-to-back: three writes exactly three cycles apart.
    start_session(16'h0200);
    bundle_and_check("b2b0", 3'b101, 5'd4, 5'd0, 5'd31, 15'h1234, 32'hA4001234, 16'h0200, 1, c1);
    bundle_and_check("b2b1", 3'b110, 5'd1, 5'd2, 5'd0,  15'h0001, ref_enc(6, 1, 2, 0, 1), 16'h0201, 2, c2);
    bundle_and_check("b2b2", 3'b000, 5'd9, 5'd8, 5'd7,  15'h0000, ref_enc(0, 9, 8, 7, 0), 16'h0202, 3, c3);
    chk("b2b_gap1", 64'(c2 - c1), 64'd3);
    chk("b2b_gap2", 64'(c3 - c2), 64'd3);
    finish_session(3);

    // finish together with in_valid: the word wins, no done pulse.
    start_session(16'h0100);
    set_fields(3'b010, 5'd1, 5'd2, 5'd3, 15'h7FFF);
    in_valid = 1'b1; finish = 1'b1;
    tick();
    in_valid = 1'b0; finish = 1'b0;
    chk("prio_wen", 64'(imem_write_en), 64'd1);
    chk("prio_nodone", 64'(done), 64'd0);
    tick(); tick();
    chk("prio_count", 64'(word_count), 64'd1);
    chk("prio_still_busy", 64'(busy), 64'd1);
    chk("prio_ready", 64'(in_ready), 64'd1);
    finish_session(1);

    // Full: four words, fifth stays pending, finish still honoured.
    start_session(16'h0300);
    for (int k = 0; k < 4; k++)
      bundle_and_check($sformatf("full%0d", k), 3'b100, 5'(k), 5'd0, 5'd0, 15'(k + 1),
                       ref_enc(4, k, 0, 0, k + 1), 16'h0300 + 16'(k), k + 1, c1);
    chk("full_flag", 64'(full), 64'd1);
    chk("full_ready", 64'(in_ready), 64'd0);
    set_fields(3'b001, 5'd1, 5'd1, 5'd1, 15'd0);
    in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("full_no_write", 64'(imem_write_en), 64'd0);
      chk("full_ready_low", 64'(in_ready), 64'd0);
    end
    finish_session(4);
    in_valid = 1'b0;

    // Readback mismatch: sticky error, start ignored, reset clears.
    start_session(16'h0400);
    bundle_and_check("err0", 3'b011, 5'd3, 5'd3, 5'd3, 15'd0, ref_enc(3, 3, 3, 3, 0), 16'h0400, 1, c1);
    send_bundle(3'b011, 5'd5, 5'd6, 5'd7, 15'd0);
    corrupt = 1'b1;
    tick(); tick();
    corrupt = 1'b0;
    chk("err_flag", 64'(error), 64'd1);
    chk("err_ready", 64'(in_ready), 64'd0);
    chk("err_busy", 64'(busy), 64'd1);
    chk("err_count", 64'(word_count), 64'd1);
    start = 1'b1; tick(); start = 1'b0;
    in_valid = 1'b1; tick(); tick();
    chk("err_start_ignored", 64'({error, busy, in_ready, imem_write_en}), 64'b1100);
    chk("err_count_held", 64'(word_count), 64'd1);
    in_valid = 1'b0;
    reset = 1'b1; tick(); reset = 1'b0;
    chk("err_reset_clear", 64'({error, busy}), 64'd0);
    chk("err_reset_count", 64'(word_count), 64'd0);
    tick();

    // Address wrap, then reset during a WRITE cycle.
    start_session(16'hFFFF);
    bundle_and_check("wrap0", 3'b101, 5'd1, 5'd1, 5'd0, 15'h0AAA, ref_enc(5, 1, 1, 0, 'h0AAA), 16'hFFFF, 1, c1);
    bundle_and_check("wrap1", 3'b010, 5'd2, 5'd2, 5'd2, 15'h0000, ref_enc(2, 2, 2, 2, 0), 16'h0000, 2, c1);
    send_bundle(3'b111, 5'd7, 5'd7, 5'd0, 15'h0777);
    chk("rstw_wen", 64'(imem_write_en), 64'd1);
    chk("rstw_addr", 64'(imem_address), 64'h0001);
    reset = 1'b1; tick(); reset = 1'b0;
    chk("rstw_wen_drop", 64'(imem_write_en), 64'd0);
    chk("rstw_busy", 64'(busy), 64'd0);
    chk("rstw_count", 64'(word_count), 64'd0);
    chk("rstw_landed", 64'(mem[1]), 64'(ref_enc(7, 7, 7, 0, 'h0777)));
    tick();
    chk("rstw_stay_idle", 64'({busy, imem_write_en}), 64'd0);

    // Randomized sessions against the field-level model.
    for (int s = 0; s < 12; s++) begin
      base = int'($urandom_range(0, 65535));
      n = int'($urandom_range(0, 4));
      start_session(16'(base));
      for (int k = 0; k < n; k++) begin
        gap = int'($urandom_range(0, 3));
        for (int g = 0; g < gap; g++) begin
          tick();
          chk("rand_idle_ready", 64'(in_ready), 64'd1);
        end
        op = 3'($urandom); r0 = 5'($urandom); r1 = 5'($urandom);
        r2 = 5'($urandom); a = 15'($urandom);
        bundle_and_check($sformatf("rand%0d_%0d", s, k), op, r0, r1, r2, a,
                         ref_enc(int'(op), int'(r0), int'(r1), int'(r2), int'(a)),
                         16'((base + k) % 65536), k + 1, c1);
      end
      chk("rand_full", 64'(full), 64'(n == int'(MAXW)));
      finish_session(n);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/instruction_writer.md
Name: instruction_writer

Overview:
- Sequential program loader; the write-side counterpart of the instruction decode path.
- Accepts instructions as separate fields (opcode, three register addresses, data address) over a valid/ready handshake.
- Packs each instruction into the 32-bit format the Decoder unpacks, then writes it into InstructionMemory at consecutive addresses.
- Reads each word back and compares it before advancing. Used by the boot/test path to load programs before the multi-cycle core starts.

Parameters:
- ADDR_W, 16, width of the instruction memory address.
- MAX_WORDS, 1024, maximum number of words written per load session.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse that opens a load session; honoured only in IDLE.
- base_addr  input  ADDR_W  first write address, latched on start.
- finish  input  1  closes the session.
- in_valid  input  1  field bundle valid.
- in_ready  output  1  block can accept a bundle.
- opcode  input  3  instruction opcode.
- reg_addr_0  input  5  destination/first register field.
- reg_addr_1  input  5  second register field.
- reg_addr_2  input  5  third register field (R-type only).
- addr  input  15  data address field (memory-type only).
- imem_address  output  ADDR_W  instruction memory address.
- imem_write_en  output  1  instruction memory write strobe.
- imem_write_data  output  32  encoded word.
- imem_read_data  input  32  combinational read port of instruction memory.
- busy  output  1  high in any state other than IDLE.
- full  output  1  count equals MAX_WORDS.
- done  output  1  one-cycle pulse when a session ends cleanly.
- error  output  1  sticky readback mismatch flag.
- word_count  output  ADDR_W+1  words committed in the current session.

Behaviour:

Encoding (combinational on the input fields; latched on accept):
- [31:29] = opcode, [28:24] = reg_addr_0, [23:19] = reg_addr_1.
- Memory-type (opcode[2]=1): [18:15] = 0, [14:0] = addr. reg_addr_2 is ignored.
- R-type (opcode[2]=0): [18:14] = reg_addr_2, [13:0] = 0. addr is ignored.

States: IDLE, ACCEPT, WRITE, CHECK, DONE, ERROR.

IDLE:
- On start, latch base_addr into wr_ptr, clear word_count and error, go to ACCEPT.
- start is ignored in every other state.

ACCEPT:
- in_ready = !full.
- If in_valid && in_ready: latch the encoded word, go to WRITE.
- Else if finish: go to DONE.
- in_valid has priority over finish when both are high in the same cycle. The word is taken and finish is dropped; finish must be reasserted.

WRITE (one cycle):
- imem_write_en = 1, imem_address = wr_ptr, imem_write_data = latched word.
- Next state is CHECK.

CHECK (one cycle):
- imem_write_en = 0, imem_address = wr_ptr.
- If imem_read_data equals the latched word: wr_ptr += 1 (wraps modulo 2^ADDR_W, 0xFFFF to 0x0000), word_count += 1, go to ACCEPT.
- Otherwise: set error, go to ERROR. wr_ptr and word_count are not advanced.

ERROR:
- busy = 1, in_ready = 0.
- Leaves only on reset. error stays high until reset or the next start.

DONE:
- done = 1 for exactly one cycle, then IDLE.
- word_count holds its value until the next start.

Full:
- full = 1 when word_count == MAX_WORDS.
- in_ready is held low while full; finish is still honoured.

Throughput: 3 cycles per word (ACCEPT, WRITE, CHECK), assuming in_valid is already high.

in_ready and imem_write_en are Moore outputs derived from state; they are never combinational on in_valid.

Reset values:
- All outputs 0; imem_address = 0, imem_write_data = 0.
- State IDLE, wr_ptr = 0, word_count = 0.

Reset mid-session: at the next edge the block returns to IDLE and imem_write_en drops. A write asserted in that same cycle still completes in memory, and no readback follows.

Test Plan:
- R-type encode: start with base 0x0010, bundle opcode=3'b010, r0=1, r1=2, r2=3, addr=0x7FFF → imem_write_data=0x4110C000 at address 0x0010 during WRITE. After CHECK, word_count=1.
- Memory-type encode: bundle opcode=3'b101, r0=4, r1=0, r2=31, addr=0x1234 → word 0xA4001234. Three back-to-back bundles land at base, base+1 and base+2, each 3 cycles apart.
- Finish priority: in_valid and finish high in the same ACCEPT cycle → word accepted, no done pulse. finish alone on a later ACCEPT cycle → done high for exactly one cycle, then busy=0.
- Full: MAX_WORDS=4, offer 5 bundles → 4 writes, full=1, in_ready stays 0 with the 5th pending. finish → done.
- Readback mismatch: bench forces imem_read_data=0xDEADBEEF during CHECK → error=1, state ERROR, in_ready=0, word_count unchanged. start is ignored; reset clears error.
- Wrap and reset: base_addr=0xFFFF, two bundles → writes at 0xFFFF then 0x0000. Assert reset during a WRITE cycle → next cycle imem_write_en=0, busy=0, word_count=0.
